// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder: memory-mapped 8N1 UART (TXD/RXD/CON) with combinational
// load data, store commit on clk, and a registered level IRQ.
module uart_mmio_responder #(
    parameter int          CLK_FREQ  = 100_000_000,
    parameter int          BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        IRQ
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    txd_q, txd_d;
    logic          tx_fin;

    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic          rx_store, rx_ferr;

    logic [1:0] ie_q, ie_d;
    logic       tx_done_q, tx_done_d, rx_valid_q, rx_valid_d;
    logic       rx_ovr_q, rx_ovr_d, ferr_q, ferr_d, irq_q, irq_d;

    logic sel_txd, sel_rxd, sel_con, tx_busy;
    logic [31:0] con_val;
    logic unused_wdata;

    assign sel_txd = Address == BASE_ADDR;
    assign sel_rxd = Address == BASE_ADDR + 32'd4;
    assign sel_con = Address == BASE_ADDR + 32'd8;
    assign tx_busy = tx_state_q != TX_IDLE;
    assign con_val = {25'b0, ferr_q, rx_ovr_q, tx_busy, rx_valid_q, tx_done_q, ie_q};
    assign unused_wdata = ^Write_data[31:8];

    assign Read_data = !MemRead ? 32'd0 :
                       sel_txd  ? {24'd0, txd_q} :
                       sel_rxd  ? {24'd0, rx_data_q} :
                       sel_con  ? con_val : 32'd0;

    // Line level is decoded from state so an async reset forces idle-high at once.
    assign uart_tx = tx_state_q == TX_START ? 1'b0 :
                     tx_state_q == TX_DATA  ? txd_q[tx_bit_q] : 1'b1;
    assign IRQ = irq_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        txd_d      = txd_q;
        tx_fin     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (MemWrite && sel_txd) begin
                    txd_d      = Write_data[7:0];
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tx_cnt_q == LAST) begin
                tx_state_d = TX_DATA;
                tx_cnt_d   = '0;
                tx_bit_d   = 3'd0;
            end
            TX_DATA: if (tx_cnt_q == LAST) begin
                tx_cnt_d   = '0;
                tx_bit_d   = tx_bit_q + 3'd1;
                tx_state_d = tx_bit_q == 3'd7 ? TX_STOP : TX_DATA;
            end
            default: if (tx_cnt_q == LAST) begin
                tx_state_d = TX_IDLE;
                tx_cnt_d   = '0;
                tx_fin     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            txd_q      <= 8'd0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            txd_q      <= txd_d;
        end
    end

    // After a bad stop bit, RX_WAIT holds off until the line is high again.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_store   = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF) begin
                rx_cnt_d   = '0;
                rx_bit_d   = 3'd0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                rx_state_d = rx_bit_q == 3'd7 ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (rx_cnt_q == LAST) begin
                rx_cnt_d   = '0;
                rx_store   = rx_sync_q;
                rx_ferr    = !rx_sync_q;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT;
            end
            default: begin
                rx_cnt_d = '0;
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
        endcase
        rx_data_d = rx_store ? rx_shift_q : rx_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_data_q  <= 8'd0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // Hardware sets take priority over read-clears.
    always_comb begin
        ie_d       = (MemWrite && sel_con) ? Write_data[1:0] : ie_q;
        tx_done_d  = tx_fin | (tx_done_q & ~(MemRead & sel_con));
        rx_valid_d = rx_store | (rx_valid_q & ~(MemRead & sel_rxd));
        rx_ovr_d   = (rx_store & rx_valid_q) | (rx_ovr_q & ~(MemRead & sel_con));
        ferr_d     = rx_ferr | (ferr_q & ~(MemRead & sel_con));
        irq_d      = (ie_q[0] & tx_done_q) | (ie_q[1] & rx_valid_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie_q       <= 2'b00;
            tx_done_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            ferr_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ie_q       <= ie_d;
            tx_done_q  <= tx_done_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            ferr_q     <= ferr_d;
            irq_q      <= irq_d;
        end
    end
endmodule

// File: tb/tb_uart_mmio_responder.sv
// tb_uart_mmio_responder: directed + randomized checks of the MMIO UART
// against a flag-level model of the register file and 8N1 framing.
module tb_uart_mmio_responder;
    localparam logic [31:0] TXD = 32'h40000018;
    localparam logic [31:0] RXD = 32'h4000001C;
    localparam logic [31:0] CON = 32'h40000020;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address, Write_data, Read_data;
    logic        MemRead, MemWrite, uart_rx, uart_tx, IRQ;

    int checks = 0;
    int errors = 0;

    logic [1:0] m_ie;
    logic       m_txd, m_rxv, m_ovr, m_ferr;
    logic [7:0] m_rxd;

    uart_mmio_responder #(.CLK_FREQ(16), .BAUD(1), .BASE_ADDR(32'h40000018)) dut (
        .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_con();
        return {25'd0, m_ferr, m_ovr, 1'b0, m_rxv, m_txd, m_ie};
    endfunction

    function automatic logic exp_irq();
        return (m_ie[0] & m_txd) | (m_ie[1] & m_rxv);
    endfunction

    task automatic model_reset();
        m_ie = 2'b00; m_txd = 1'b0; m_rxv = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_rxd = 8'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Address = a; Write_data = d; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        if (a == CON) m_ie = d[1:0];
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        Address = a; MemRead = 1'b1;
        #1 d = Read_data;
        MemRead = 1'b0;
    endtask

    task automatic rd_con(input string tag);
        logic [31:0] d;
        Address = CON; MemRead = 1'b1;
        #1 d = Read_data;
        @(negedge clk);
        MemRead = 1'b0;
        chk(tag, d, exp_con());
        m_txd = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic rd_rxd(input string tag);
        logic [31:0] d;
        Address = RXD; MemRead = 1'b1;
        #1 d = Read_data;
        @(negedge clk);
        MemRead = 1'b0;
        chk(tag, d, {24'd0, m_rxd});
        m_rxv = 1'b0;
    endtask

    // Full frame check: per-cycle line level and busy bit, then done flag and IRQ.
    task automatic tx_frame(input logic [7:0] b, input int inj);
        logic [9:0]  f;
        logic [31:0] d;
        int bad_tx, bad_busy;
        f = {1'b1, b, 1'b0};
        bad_tx = 0; bad_busy = 0;
        wr(TXD, {24'd0, b});
        for (int t = 1; t <= 160; t++) begin
            if (uart_tx !== f[(t - 1) / 16]) bad_tx++;
            peek(CON, d);
            if (d[4] !== 1'b1) bad_busy++;
            if (t == inj) wr(TXD, 32'h3C); else tick(1);
        end
        chk("tx_wave", 32'(bad_tx), 32'd0);
        chk("tx_busy", 32'(bad_busy), 32'd0);
        m_txd = 1'b1;
        peek(CON, d);
        chk("tx_done_con", d, exp_con());
        tick(1);
        chk("tx_irq", {31'd0, IRQ}, {31'd0, exp_irq()});
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            tick(16);
        end
        uart_rx = 1'b1;
        tick(4);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        send_rx(b, stop);
        if (stop) begin
            if (m_rxv) m_ovr = 1'b1;
            m_rxv = 1'b1;
            m_rxd = b;
        end else m_ferr = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int bad;
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Address = 32'd0;
        Write_data = 32'd0; uart_rx = 1'b1;
        model_reset();
        tick(3);
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        chk("rst_rdata", Read_data, 32'd0);
        reset = 1'b1;
        tick(2);
        rd_con("rst_con");
        rd_rxd("rst_rxd");
        peek(BASE_UNMAPPED(), d);
        chk("unmapped_rd", d, 32'd0);

        wr(CON, 32'h1);
        tx_frame(8'hA5, 0);
        peek(TXD, d);
        chk("txd_rd", d, 32'hA5);
        rd_con("con_a5");
        chk("irq_hold", {31'd0, IRQ}, 32'd1);
        tick(1);
        chk("irq_drop", {31'd0, IRQ}, 32'd0);

        tx_frame(8'hA5, 40);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            peek(CON, d);
            if (uart_tx !== 1'b1 || d[4] !== 1'b0) bad++;
            tick(1);
        end
        chk("tx_drop", 32'(bad), 32'd0);
        rd_con("con_drop");

        for (int k = 0; k < 3; k++) begin
            wr(CON, 32'($urandom_range(0, 3)));
            tx_frame(8'($urandom_range(0, 255)), 0);
            rd_con("con_rand_tx");
            tick(2);
            chk("irq_rand_tx", {31'd0, IRQ}, {31'd0, exp_irq()});
        end

        wr(CON, 32'h2);
        rx_frame(8'h5A, 1'b1);
        chk("rx_irq", {31'd0, IRQ}, 32'd1);
        peek(CON, d);
        chk("rx_valid", d, exp_con());
        rd_rxd("rxd_5a");
        peek(CON, d);
        chk("rx_valid_clr", d, exp_con());
        tick(2);
        chk("rx_irq_drop", {31'd0, IRQ}, 32'd0);

        for (int k = 0; k < 3; k++) begin
            rx_frame(8'($urandom_range(0, 255)), 1'b1);
            rd_rxd("rxd_rand");
        end

        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        rd_con("con_ovr");
        rd_rxd("rxd_ovr");
        rd_con("con_ovr_clr");

        rx_frame(8'h33, 1'b0);
        tick(5);
        rd_con("con_ferr");
        rd_con("con_ferr_clr");
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(40);
        rd_con("con_glitch");
        rx_frame(8'($urandom_range(0, 255)), 1'b1);
        rd_rxd("rxd_after_glitch");

        wr(CON, 32'h1);
        b = 8'($urandom_range(0, 255)) & 8'hEF;
        wr(TXD, {24'd0, b});
        tick(87);
        chk("tx_bit4_low", {31'd0, uart_tx}, 32'd0);
        #2 reset = 1'b0;
        #1 chk("tx_async_rst", {31'd0, uart_tx}, 32'd1);
        model_reset();
        peek(CON, d);
        chk("tx_rst_con", d, 32'd0);
        tick(1);
        reset = 1'b1;
        tick(2);
        tx_frame(8'($urandom_range(0, 255)), 0);
        rd_con("con_after_tx_rst");

        wr(CON, 32'h2);
        fork
            send_rx(8'($urandom_range(0, 255)), 1'b1);
            begin
                tick(88);
                #2 reset = 1'b0;
                #1 model_reset();
                peek(CON, d);
                chk("rx_rst_con", d, 32'd0);
                peek(RXD, d);
                chk("rx_rst_rxd", d, 32'd0);
                chk("rx_rst_irq", {31'd0, IRQ}, 32'd0);
            end
        join
        reset = 1'b1;
        tick(2);
        rx_frame(8'($urandom_range(0, 255)), 1'b1);
        rd_rxd("rxd_after_rst");
        rd_con("con_after_rx_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [31:0] BASE_UNMAPPED();
        return TXD + 32'd12;
    endfunction
endmodule
